next_pc_unit: RTL and testbench

Parametrised next-PC resolver for the multi-cycle MIPS core; it supersedes the fixed-width jump stage. It accepts one control-transfer request per handshake and classifies it as sequential, J, JAL, JR, BEQ, BNE or RET. It computes the word-addressed next PC, produces the JAL link value and flags misaligned register targets. It sits between the decode/register-read stage and the PC register.

---
 rtl/next_pc_if.sv | 31 +++
 rtl/next_pc_unit.sv | 229 ++++++++++++++++++++++
 tb/tb_next_pc_unit.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/next_pc_if.sv
// rtl/next_pc_if.sv - request/result bundle between decode stage and next_pc_unit
interface next_pc_if #(
  parameter int PC_W   = 32,
  parameter int ADDR_W = 26,
  parameter int IMM_W  = 16
);
  logic              en;
  logic [2:0]        kind;
  logic [PC_W-1:0]   pc;
  logic [ADDR_W-1:0] addr;
  logic [IMM_W-1:0]  imm;
  logic [31:0]       reg_addr;
  logic [31:0]       cmp_a;
  logic [31:0]       cmp_b;
  logic [PC_W-1:0]   pc_out;
  logic [PC_W-1:0]   link_out;
  logic              link_we;
  logic              done;
  logic              busy;
  logic              err;

  modport master (
    output en, kind, pc, addr, imm, reg_addr, cmp_a, cmp_b,
    input  pc_out, link_out, link_we, done, busy, err
  );

  modport slave (
    input  en, kind, pc, addr, imm, reg_addr, cmp_a, cmp_b,
    output pc_out, link_out, link_we, done, busy, err
  );
endinterface

// File: rtl/next_pc_unit.sv
// rtl/next_pc_unit.sv - next-PC resolver (seq/J/JAL/JR/BEQ/BNE/RET), IDLE->CALC->DONE
// Optional return-address stack compiled in with NEXT_PC_RAS_EN.
module next_pc_unit #(
  parameter int PC_W      = 32,
  parameter int ADDR_W    = 26,
  parameter int IMM_W     = 16,
  parameter int RAS_DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  next_pc_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam logic [2:0] K_J   = 3'd1;
  localparam logic [2:0] K_JAL = 3'd2;
  localparam logic [2:0] K_JR  = 3'd3;
  localparam logic [2:0] K_BEQ = 3'd4;
  localparam logic [2:0] K_BNE = 3'd5;
  localparam logic [2:0] K_RET = 3'd6;

  if (PC_W < 27 || PC_W > 32 || ADDR_W >= PC_W || IMM_W >= PC_W ||
      RAS_DEPTH < 2 || RAS_DEPTH > 16 || (RAS_DEPTH & (RAS_DEPTH - 1)) != 0) begin : g_bad_params
    $error("next_pc_unit: illegal parameter combination");
  end

  state_t            state_q, state_d;
  logic [2:0]        kind_q, kind_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [IMM_W-1:0]  imm_q, imm_d;
  logic [31:0]       reg_addr_q, reg_addr_d;
  logic [31:0]       cmp_a_q, cmp_a_d;
  logic [31:0]       cmp_b_q, cmp_b_d;
  logic [PC_W-1:0]   res_pc_q, res_pc_d;
  logic              res_err_q, res_err_d;
  logic [PC_W-1:0]   pc_out_q, pc_out_d;
  logic [PC_W-1:0]   link_out_q, link_out_d;
  logic              link_we_q, link_we_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;

  logic [PC_W-1:0]   pc_inc;
  logic [PC_W-1:0]   br_tgt;
  logic [PC_W-1:0]   jr_tgt;
  logic              jr_mis;
  logic [33:0]       reg_addr_ext;
  logic [PC_W-1:0]   tgt;
  logic              tgt_err;

`ifdef NEXT_PC_RAS_EN
  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PC_W-1:0]  ras_q [RAS_DEPTH];
  logic [PC_W-1:0]  ras_d [RAS_DEPTH];
  logic [PTR_W-1:0] ras_ptr_q, ras_ptr_d;
  logic [CNT_W-1:0] ras_cnt_q, ras_cnt_d;
  logic [PTR_W-1:0] ras_top;

  assign ras_top = ras_ptr_q - PTR_W'(1);
`endif

  // Target evaluation works only on the latched request.
  always_comb begin
    pc_inc       = pc_q + PC_W'(1);
    br_tgt       = pc_inc + {{(PC_W-IMM_W){imm_q[IMM_W-1]}}, imm_q};
    reg_addr_ext = {2'b00, reg_addr_q};
    jr_tgt       = reg_addr_ext[PC_W+1:2];
    jr_mis       = (reg_addr_q[1:0] != 2'b00);
    tgt          = pc_inc;
    tgt_err      = 1'b0;
    case (kind_q)
      K_J, K_JAL: tgt = {pc_q[PC_W-1:ADDR_W], addr_q};
      K_BEQ:      tgt = (cmp_a_q == cmp_b_q) ? br_tgt : pc_inc;
      K_BNE:      tgt = (cmp_a_q != cmp_b_q) ? br_tgt : pc_inc;
`ifdef NEXT_PC_RAS_EN
      K_RET: begin
        if (ras_cnt_q == '0) begin
          tgt_err = 1'b1;
        end else begin
          tgt = ras_q[ras_top];
        end
      end
      K_JR: begin
`else
      K_JR, K_RET: begin
`endif
        if (jr_mis) begin
          tgt_err = 1'b1;
        end else begin
          tgt = jr_tgt;
        end
      end
      default: tgt = pc_inc;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    kind_d     = kind_q;
    pc_d       = pc_q;
    addr_d     = addr_q;
    imm_d      = imm_q;
    reg_addr_d = reg_addr_q;
    cmp_a_d    = cmp_a_q;
    cmp_b_d    = cmp_b_q;
    res_pc_d   = res_pc_q;
    res_err_d  = res_err_q;
    pc_out_d   = pc_out_q;
    link_out_d = link_out_q;
    link_we_d  = 1'b0;
    done_d     = 1'b0;
    busy_d     = busy_q;
    err_d      = err_q;
`ifdef NEXT_PC_RAS_EN
    ras_d      = ras_q;
    ras_ptr_d  = ras_ptr_q;
    ras_cnt_d  = ras_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.en) begin
          kind_d     = bus.kind;
          pc_d       = bus.pc;
          addr_d     = bus.addr;
          imm_d      = bus.imm;
          reg_addr_d = bus.reg_addr;
          cmp_a_d    = bus.cmp_a;
          cmp_b_d    = bus.cmp_b;
          busy_d     = 1'b1;
          err_d      = 1'b0;
          state_d    = CALC;
        end
      end
      CALC: begin
        res_pc_d  = tgt;
        res_err_d = tgt_err;
        state_d   = DONE;
      end
      DONE: begin
        // All architectural updates land on this edge so a reset before it leaves no trace.
        pc_out_d = res_pc_q;
        err_d    = res_err_q;
        done_d   = 1'b1;
        busy_d   = 1'b0;
        if (kind_q == K_JAL) begin
          link_out_d = pc_inc;
          link_we_d  = 1'b1;
`ifdef NEXT_PC_RAS_EN
          ras_d[ras_ptr_q] = pc_inc;
          ras_ptr_d        = ras_ptr_q + PTR_W'(1);
          if (ras_cnt_q != CNT_W'(RAS_DEPTH)) begin
            ras_cnt_d = ras_cnt_q + CNT_W'(1);
          end
`endif
        end
`ifdef NEXT_PC_RAS_EN
        if (kind_q == K_RET && ras_cnt_q != '0) begin
          ras_ptr_d = ras_top;
          ras_cnt_d = ras_cnt_q - CNT_W'(1);
        end
`endif
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      kind_q     <= '0;
      pc_q       <= '0;
      addr_q     <= '0;
      imm_q      <= '0;
      reg_addr_q <= '0;
      cmp_a_q    <= '0;
      cmp_b_q    <= '0;
      res_pc_q   <= '0;
      res_err_q  <= 1'b0;
      pc_out_q   <= '0;
      link_out_q <= '0;
      link_we_q  <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      kind_q     <= kind_d;
      pc_q       <= pc_d;
      addr_q     <= addr_d;
      imm_q      <= imm_d;
      reg_addr_q <= reg_addr_d;
      cmp_a_q    <= cmp_a_d;
      cmp_b_q    <= cmp_b_d;
      res_pc_q   <= res_pc_d;
      res_err_q  <= res_err_d;
      pc_out_q   <= pc_out_d;
      link_out_q <= link_out_d;
      link_we_q  <= link_we_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
    end
  end

`ifdef NEXT_PC_RAS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RAS_DEPTH; i++) ras_q[i] <= '0;
      ras_ptr_q <= '0;
      ras_cnt_q <= '0;
    end else begin
      ras_q     <= ras_d;
      ras_ptr_q <= ras_ptr_d;
      ras_cnt_q <= ras_cnt_d;
    end
  end
`endif

  assign bus.pc_out   = pc_out_q;
  assign bus.link_out = link_out_q;
  assign bus.link_we  = link_we_q;
  assign bus.done     = done_q;
  assign bus.busy     = busy_q;
  assign bus.err      = err_q;
endmodule

// File: tb/tb_next_pc_unit.sv
// tb/tb_next_pc_unit.sv - directed and randomized checks of next_pc_unit against a behavioural model
module tb_next_pc_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   passed = 0;
  int   total = 0;

  logic [31:0] exp_pc = '0;
  logic [31:0] exp_link = '0;
  logic [31:0] ras_model[$];

  next_pc_if #(.PC_W(32), .ADDR_W(26), .IMM_W(16)) bus ();

  next_pc_unit #(.PC_W(32), .ADDR_W(26), .IMM_W(16), .RAS_DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Architectural meaning of each request kind, without any notion of cycles.
  function automatic void model(input logic [2:0] k, input logic [31:0] p, input logic [25:0] ad,
                                input logic [15:0] im, input logic [31:0] ra, input logic [31:0] ca,
                                input logic [31:0] cb, output logic [31:0] t, output logic e);
    logic [31:0] nxt;
    logic [31:0] taken;
    nxt   = p + 32'd1;
    taken = nxt + 32'(int'($signed(im)));
    e     = 1'b0;
    case (k)
      3'd1, 3'd2: t = (p & 32'hFC00_0000) | 32'(ad);
      3'd3, 3'd6: begin
        if (ra % 4 != 0) begin
          t = nxt;
          e = 1'b1;
        end else begin
          t = ra / 4;
        end
      end
      3'd4:    t = (ca == cb) ? taken : nxt;
      3'd5:    t = (ca != cb) ? taken : nxt;
      default: t = nxt;
    endcase
  endfunction

  task automatic scramble();
    bus.kind     = 3'($urandom);
    bus.pc       = $urandom;
    bus.addr     = 26'($urandom);
    bus.imm      = 16'($urandom);
    bus.reg_addr = $urandom;
    bus.cmp_a    = $urandom;
    bus.cmp_b    = $urandom;
  endtask

  task automatic req(input logic [2:0] k, input logic [31:0] p, input logic [25:0] ad,
                     input logic [15:0] im, input logic [31:0] ra, input logic [31:0] ca,
                     input logic [31:0] cb);
    logic [31:0] t;
    logic        e;
    model(k, p, ad, im, ra, ca, cb, t, e);
`ifdef NEXT_PC_RAS_EN
    if (k == 3'd6) begin
      if (ras_model.size() > 0) begin
        t = ras_model.pop_back();
        e = 1'b0;
      end else begin
        t = p + 32'd1;
        e = 1'b1;
      end
    end
    if (k == 3'd2) begin
      ras_model.push_back(p + 32'd1);
      if (ras_model.size() > 4) void'(ras_model.pop_front());
    end
`endif
    if (k == 3'd2) exp_link = p + 32'd1;
    exp_pc = t;
    @(negedge clk);
    bus.kind = k; bus.pc = p; bus.addr = ad; bus.imm = im;
    bus.reg_addr = ra; bus.cmp_a = ca; bus.cmp_b = cb;
    bus.en = 1'b1;
    @(posedge clk); #1;
    bus.en = 1'b0;
    scramble();
    check("busy_calc", 32'(bus.busy), 32'd1);
    check("done_calc", 32'(bus.done), 32'd0);
    check("err_clear", 32'(bus.err), 32'd0);
    @(posedge clk); #1;
    check("busy_wait", 32'(bus.busy), 32'd1);
    check("done_wait", 32'(bus.done), 32'd0);
    @(posedge clk); #1;
    check("done", 32'(bus.done), 32'd1);
    check("pc_out", bus.pc_out, exp_pc);
    check("err", 32'(bus.err), 32'(e));
    check("link_we", 32'(bus.link_we), 32'(k == 3'd2));
    check("link_out", bus.link_out, exp_link);
    check("busy_done", 32'(bus.busy), 32'd0);
    @(posedge clk); #1;
    check("done_pulse", 32'(bus.done), 32'd0);
    check("link_we_pulse", 32'(bus.link_we), 32'd0);
  endtask

  initial begin
    int          dones;
    int          first_done;
    int          second_done;
    logic [2:0]  k;
    logic [31:0] p;
    logic [31:0] ra;
    logic [31:0] ca;

    bus.en = 1'b0;
    scramble();
    #12;
    check("rst_pc_out", bus.pc_out, 32'd0);
    check("rst_link_out", bus.link_out, 32'd0);
    check("rst_link_we", 32'(bus.link_we), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    @(negedge clk) rst = 1'b0;

    req(3'd1, 32'h0400_0010, 26'h000_0123, 16'h0, 32'h0, 32'h0, 32'h0);
    check("j_spec", bus.pc_out, 32'h0400_0123);
    req(3'd2, 32'h0000_0020, 26'h000_0040, 16'h0, 32'h0, 32'h0, 32'h0);
    check("jal_link_spec", bus.link_out, 32'h0000_0021);

    // Abort a request in its CALC cycle.
    @(negedge clk);
    bus.kind = 3'd1; bus.pc = 32'h0400_0010; bus.addr = 26'h3FF_FFFF; bus.en = 1'b1;
    @(posedge clk); #1;
    bus.en = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("abort_pc_out", bus.pc_out, 32'd0);
    check("abort_link_out", bus.link_out, 32'd0);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_err", 32'(bus.err), 32'd0);
    @(negedge clk) rst = 1'b0;
    exp_pc = '0;
    exp_link = '0;
    ras_model.delete();
    dones = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      if (bus.done) dones++;
    end
    check("abort_no_done", 32'(dones), 32'd0);
    check("abort_pc_hold", bus.pc_out, 32'd0);

    req(3'd3, 32'h0000_0077, 26'h0, 16'h0, 32'h0000_0400, 32'h0, 32'h0);
    check("jr_spec", bus.pc_out, 32'h0000_0100);
    req(3'd3, 32'h0000_0050, 26'h0, 16'h0, 32'h0000_0402, 32'h0, 32'h0);
    check("jr_mis_spec", bus.pc_out, 32'h0000_0051);
    req(3'd4, 32'h0000_0010, 26'h0, 16'hFFFE, 32'h0, 32'h1234, 32'h1234);
    check("beq_taken_spec", bus.pc_out, 32'h0000_000F);
    req(3'd4, 32'h0000_0010, 26'h0, 16'hFFFE, 32'h0, 32'h1234, 32'h1235);
    check("beq_not_spec", bus.pc_out, 32'h0000_0011);
    req(3'd5, 32'h0000_0010, 26'h0, 16'h0004, 32'h0, 32'h1, 32'h2);
    check("bne_spec", bus.pc_out, 32'h0000_0015);
    req(3'd0, 32'hFFFF_FFFF, 26'h0, 16'h0, 32'h0, 32'h0, 32'h0);
    check("seq_wrap_spec", bus.pc_out, 32'h0000_0000);
    req(3'd4, 32'h0000_0000, 26'h0, 16'hFFFE, 32'h0, 32'h5, 32'h5);
    check("beq_wrap_spec", bus.pc_out, 32'hFFFF_FFFF);
    req(3'd7, 32'h0000_1000, 26'h0, 16'h0, 32'h0, 32'h0, 32'h0);

`ifdef NEXT_PC_RAS_EN
    for (int i = 1; i <= 5; i++) req(3'd2, 32'(i * 16), 26'h0, 16'h0, 32'h0, 32'h0, 32'h0);
    for (int i = 0; i < 5; i++) req(3'd6, 32'h0000_0100, 26'h0, 16'h0, 32'h0, 32'h0, 32'h0);
    check("ras_underflow", bus.pc_out, 32'h0000_0101);
`else
    req(3'd6, 32'h0000_0100, 26'h0, 16'h0, 32'h0000_0800, 32'h0, 32'h0);
    check("ret_as_jr", bus.pc_out, 32'h0000_0200);
    req(3'd6, 32'h0000_0100, 26'h0, 16'h0, 32'h0000_0801, 32'h0, 32'h0);
`endif

    // en held for six edges: accepts at edges 0 and 3, done after edges 2 and 5.
    @(negedge clk);
    bus.kind = 3'd0; bus.pc = 32'h0000_0AA0; bus.en = 1'b1;
    dones = 0;
    first_done = -1;
    second_done = -1;
    for (int c = 0; c < 9; c++) begin
      @(posedge clk); #1;
      if (c == 5) bus.en = 1'b0;
      if (bus.done) begin
        if (dones == 0) first_done = c;
        else second_done = c;
        dones++;
      end
    end
    check("hold_en_dones", 32'(dones), 32'd2);
    check("hold_en_first", 32'(first_done), 32'd2);
    check("hold_en_second", 32'(second_done), 32'd5);
    check("hold_en_pc", bus.pc_out, 32'h0000_0AA1);

    for (int n = 0; n < 150; n++) begin
      k  = 3'($urandom_range(0, 7));
      p  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
      ra = $urandom;
      if ($urandom_range(0, 1) == 1) ra = ra & 32'hFFFF_FFFC;
      ca = $urandom;
      req(k, p, 26'($urandom), 16'($urandom), ra, ca, ($urandom_range(0, 1) == 1) ? ca : $urandom);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
